core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 141 ++++++++++++++
 tb/tb_core_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/mem/writeback control FSM.
// Latency: 4 cycles to retire ALU/branch/store, 5 for loads, +1 per ack wait cycle.
// Backpressure: FETCH and MEM hold their request until the matching ack arrives.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   imem_req / imem_ack           instruction fetch handshake
//   ir_wren                       instruction register load strobe
//   dec_*                         decoder flags for the instruction in flight
//   dmem_req / dmem_we / dmem_ack data memory handshake
//   reg_wren, pc_wren             register-file write and retire strobes
//   halted, state                 status
// Optional feature: define CORE_SEQUENCER_PERF_COUNTER_EN to add the
// cycle_count and retired_count performance counters.

module core_sequencer #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       ir_wren,
  input  logic       dec_reg_wren,
  input  logic       dec_ram_wren,
  input  logic       dec_is_load,
  input  logic       dec_illegal,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       reg_wren,
  output logic       pc_wren,
  output logic       halted,
  output logic [2:0] state
`ifdef CORE_SEQUENCER_PERF_COUNTER_EN
  ,
  output logic [COUNTER_WIDTH-1:0] cycle_count,
  output logic [COUNTER_WIDTH-1:0] retired_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  // A zero or negative width leaves nothing sensible to count with.
  if (COUNTER_WIDTH < 1) begin : g_bad_counter_width
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    ir_wren  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_wren = 1'b0;
    pc_wren  = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_wren  = imem_ack;
        if (imem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = dec_illegal ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        w_next = (dec_is_load || dec_ram_wren) ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_ram_wren;
        if (dmem_ack) begin
          // Stores retire straight from MEM; loads still owe a register write.
          if (dec_ram_wren) begin
            pc_wren = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next  = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        reg_wren = dec_reg_wren;
        pc_wren  = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
    // Outputs are silent for the whole reset window, even before the first edge.
    if (rst) begin
      imem_req = 1'b0;
      ir_wren  = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      reg_wren = 1'b0;
      pc_wren  = 1'b0;
      halted   = 1'b0;
    end
  end

  assign state = r_state;

`ifdef CORE_SEQUENCER_PERF_COUNTER_EN
  logic [COUNTER_WIDTH-1:0] r_cycle_count;
  logic [COUNTER_WIDTH-1:0] r_retired_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_count   <= '0;
      r_retired_count <= '0;
    end else begin
      if (r_state != S_HALT) r_cycle_count <= r_cycle_count + 1'b1;
      if (pc_wren)           r_retired_count <= r_retired_count + 1'b1;
    end
  end

  assign cycle_count   = r_cycle_count;
  assign retired_count = r_retired_count;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle state and output vectors
// compared against hand-computed expectations.
module tb_core_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_req, imem_ack = 1'b0, ir_wren;
  logic       dec_reg_wren = 1'b0, dec_ram_wren = 1'b0;
  logic       dec_is_load = 1'b0, dec_illegal = 1'b0;
  logic       dmem_req, dmem_we, dmem_ack = 1'b0;
  logic       reg_wren, pc_wren, halted;
  logic [2:0] state;
`ifdef CORE_SEQUENCER_PERF_COUNTER_EN
  logic [3:0] cycle_count, retired_count;
`endif

  int checks   = 0;
  int failures = 0;

  // {imem_req, ir_wren, dmem_req, dmem_we, reg_wren, pc_wren, halted}
  logic [6:0] outs;
  assign outs = {imem_req, ir_wren, dmem_req, dmem_we, reg_wren, pc_wren, halted};

  core_sequencer #(.COUNTER_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .ir_wren      (ir_wren),
    .dec_reg_wren (dec_reg_wren),
    .dec_ram_wren (dec_ram_wren),
    .dec_is_load  (dec_is_load),
    .dec_illegal  (dec_illegal),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .reg_wren     (reg_wren),
    .pc_wren      (pc_wren),
    .halted       (halted),
    .state        (state)
`ifdef CORE_SEQUENCER_PERF_COUNTER_EN
    ,
    .cycle_count  (cycle_count),
    .retired_count(retired_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered just after a falling edge: drive acks, check this cycle, move to the next falling edge.
  task automatic at(input string tag, input logic ia, input logic da,
                    input logic [2:0] st, input logic [6:0] o);
    imem_ack = ia;
    dmem_ack = da;
    #1;
    chk({tag, "_state"}, {29'd0, state}, {29'd0, st});
    chk({tag, "_outs"}, {25'd0, outs}, {25'd0, o});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_outs", {25'd0, outs}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic set_dec(input logic rw, input logic sw, input logic ld, input logic il);
    dec_reg_wren = rw;
    dec_ram_wren = sw;
    dec_is_load  = ld;
    dec_illegal  = il;
  endtask

  initial begin
    // Zero-wait ADD with imem_ack tied high.
    set_dec(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    at("add_c1", 1'b1, 1'b0, 3'd0, 7'b1100000);
    at("add_c2", 1'b1, 1'b0, 3'd1, 7'b0000000);
    at("add_c3", 1'b1, 1'b0, 3'd2, 7'b0000000);
    at("add_c4", 1'b1, 1'b0, 3'd4, 7'b0000110);
    at("add_c5", 1'b0, 1'b0, 3'd0, 7'b1000000);

    // Load: imem_ack after 2 wait cycles, dmem_ack after 3; stray acks in other states.
    set_dec(1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();
    at("ld_c1", 1'b0, 1'b0, 3'd0, 7'b1000000);
    at("ld_c2", 1'b0, 1'b1, 3'd0, 7'b1000000);
    at("ld_c3", 1'b1, 1'b0, 3'd0, 7'b1100000);
    at("ld_c4", 1'b1, 1'b1, 3'd1, 7'b0000000);
    at("ld_c5", 1'b1, 1'b1, 3'd2, 7'b0000000);
    at("ld_c6", 1'b0, 1'b0, 3'd3, 7'b0010000);
    at("ld_c7", 1'b1, 1'b0, 3'd3, 7'b0010000);
    at("ld_c8", 1'b0, 1'b0, 3'd3, 7'b0010000);
    at("ld_c9", 1'b1, 1'b1, 3'd3, 7'b0010000);
    at("ld_c10", 1'b0, 1'b0, 3'd4, 7'b0000110);
    at("ld_c11", 1'b0, 1'b0, 3'd0, 7'b1000000);

    // Store with no register write; one ack wait cycle in MEM.
    set_dec(1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    at("st_c1", 1'b1, 1'b0, 3'd0, 7'b1100000);
    at("st_c2", 1'b0, 1'b0, 3'd1, 7'b0000000);
    at("st_c3", 1'b0, 1'b0, 3'd2, 7'b0000000);
    at("st_c4", 1'b0, 1'b0, 3'd3, 7'b0011000);
    at("st_c5", 1'b0, 1'b1, 3'd3, 7'b0011010);
    at("st_c6", 1'b0, 1'b0, 3'd0, 7'b1000000);

    // Illegal opcode: HALT is sticky through any ack pattern until reset.
    set_dec(1'b1, 1'b0, 1'b0, 1'b1);
    do_reset();
    at("ill_c1", 1'b1, 1'b0, 3'd0, 7'b1100000);
    at("ill_c2", 1'b0, 1'b1, 3'd1, 7'b0000000);
    for (int i = 0; i < 20; i++) begin
      at("halt", i[0], ~i[0], 3'd5, 7'b0000001);
    end
    set_dec(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    at("post_halt", 1'b0, 1'b0, 3'd0, 7'b1000000);

    // Reset in MEM with dmem_ack low; a late dmem_ack in FETCH does nothing.
    set_dec(1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    at("rm_c1", 1'b1, 1'b0, 3'd0, 7'b1100000);
    at("rm_c2", 1'b0, 1'b0, 3'd1, 7'b0000000);
    at("rm_c3", 1'b0, 1'b0, 3'd2, 7'b0000000);
    at("rm_c4", 1'b0, 1'b0, 3'd3, 7'b0011000);
    rst = 1'b1;
    at("rm_rst_in_mem", 1'b0, 1'b0, 3'd3, 7'b0000000);
    at("rm_rst_held", 1'b0, 1'b0, 3'd0, 7'b0000000);
    rst = 1'b0;
    at("rm_late_ack1", 1'b0, 1'b1, 3'd0, 7'b1000000);
    at("rm_late_ack2", 1'b0, 1'b1, 3'd0, 7'b1000000);

`ifdef CORE_SEQUENCER_PERF_COUNTER_EN
    // 16 zero-wait ADDs wrap a 4-bit retired counter back to 0.
    set_dec(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("cnt_rst_cycle", {28'd0, cycle_count}, 32'd0);
    chk("cnt_rst_retired", {28'd0, retired_count}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      at("cnt_f", 1'b1, 1'b0, 3'd0, 7'b1100000);
      at("cnt_d", 1'b1, 1'b0, 3'd1, 7'b0000000);
      at("cnt_e", 1'b1, 1'b0, 3'd2, 7'b0000000);
      at("cnt_w", 1'b1, 1'b0, 3'd4, 7'b0000110);
      if (k == 4) begin
        chk("cnt_mid_cycle", {28'd0, cycle_count}, 32'd4);     // 20 mod 16
        chk("cnt_mid_retired", {28'd0, retired_count}, 32'd5);
      end
    end
    chk("cnt_wrap_cycle", {28'd0, cycle_count}, 32'd0);        // 64 mod 16
    chk("cnt_wrap_retired", {28'd0, retired_count}, 32'd0);    // 16 mod 16
    for (int k = 0; k < 3; k++) at("cnt_idle", 1'b0, 1'b0, 3'd0, 7'b1000000);
    chk("cnt_idle_cycle", {28'd0, cycle_count}, 32'd3);        // 67 mod 16
    set_dec(1'b1, 1'b0, 1'b0, 1'b1);
    at("cnt_ill_f", 1'b1, 1'b0, 3'd0, 7'b1100000);
    at("cnt_ill_d", 1'b0, 1'b0, 3'd1, 7'b0000000);
    for (int k = 0; k < 5; k++) at("cnt_halt", 1'b1, 1'b1, 3'd5, 7'b0000001);
    chk("cnt_halt_cycle", {28'd0, cycle_count}, 32'd5);        // 69 mod 16, frozen in HALT
    chk("cnt_halt_retired", {28'd0, retired_count}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
